riscv_mc_controller: RTL
========================

# riscv_mc_controller

Parametrised multi-cycle RISC-V control unit. It replaces the fixed main/ALU/branch decoder trio with a single FSM-based controller. It sequences fetch, decode, execute, memory and writeback for RV32I (R, I-ALU, lw, sw, all six branches, jal, jalr, lui), with an optional memory-ready handshake and an optional M-extension multi-cycle mul/div handshake. It sits between the instruction register / flag outputs of the datapath and all datapath mux selects and write strobes.

## Interface
- MEM_HANDSHAKE, 0, 1: memory states wait for `mem_ready`; 0: `mem_ready` is ignored (treated as 1).
- MEXT, 0, 1: R-type ops with func7=0000001 go to the external mul/div unit; 0: such ops are illegal.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- op / func3 / func7  in  7/3/7  fields from the instruction register.
- zero, neg, ltu  in  1 each  ALU flags: result==0, signed less-than, unsigned less-than.
- mem_ready  in  1  memory access complete this cycle.
- md_done  in  1  mul/div result valid, single-cycle pulse.
- PCWrite, adrSrc, memWrite, IRWrite, regWrite  out  1 each  datapath strobes and selects.
- resultSrc  out  2  00 ALUOut, 01 mem data, 10 ALU result, 11 mul/div result.
- ALUSrcA  out  2  00 PC, 01 oldPC, 10 rs1, 11 zero.
- ALUSrcB  out  2  00 rs2, 01 imm, 10 const 4.
- ALUControl  out  4  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra.
- immSrc  out  3  0 I, 1 S, 2 B, 3 J, 4 U.
- md_start  out  1  one-cycle launch pulse to the mul/div unit.
- illegal  out  1  high while in TRAP.

## Operation
- PCWrite = PCUpdate | (branch & taken). Branch conditions by func3: 000 zero, 001 !zero, 100 neg, 101 !neg, 110 ltu, 111 !ltu. Any other func3 on a branch goes to TRAP.
- Outputs are Moore from the state register. The exceptions are PCWrite in BRANCH (depends on flags) and the FETCH/MEMWRITE strobes (gated by mem_ready). All strobes default to 0 and all selects to 0 unless listed below.
- FETCH: adrSrc 0, ALUSrcA 00, ALUSrcB 10, add, resultSrc 10; IRWrite = PCUpdate = mem_ready. Leave to DECODE when mem_ready, otherwise stay.
- DECODE: ALUSrcA 01, ALUSrcB 01, add, immSrc B for branch / J for jal (this computes the target). Next state by op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR, or MD_START when MEXT and func7=0000001
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI
  - anything else → TRAP
- MEMADR: ALUSrcA 10, ALUSrcB 01, add, immSrc I for lw / S for sw. Next: MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: adrSrc 1. Go to MEMWB on mem_ready.
- MEMWB: resultSrc 01, regWrite. Then FETCH.
- MEMWRITE: adrSrc 1, memWrite held until mem_ready. Go to FETCH on mem_ready.
- EXECR / EXECI: ALUSrcA 10, ALUSrcB 00 (R) or 01 (I, immSrc I). ALUControl from func3 with func7[5]; sub applies only to R-type, sra applies to both. Unsupported func3/func7 combinations go to TRAP. Next: ALUWB.
- ALUWB: resultSrc 00, regWrite. Then FETCH.
- BRANCH: ALUSrcA 10, ALUSrcB 00, sub, resultSrc 00, branch=1. Then FETCH.
- JAL: ALUSrcA 01, ALUSrcB 10, add, resultSrc 00, PCUpdate. Then ALUWB (writes oldPC+4).
- JALR: ALUSrcA 10, ALUSrcB 01, immSrc I, add, resultSrc 10, PCUpdate. Then LINK.
- LINK: ALUSrcA 01, ALUSrcB 10, add, resultSrc 10, regWrite. Then FETCH.
- LUI: ALUSrcA 11, ALUSrcB 01, immSrc U, add. Then ALUWB.
- MD_START: md_start=1. Then MD_WAIT.
- MD_WAIT: wait for md_done, then MD_WB. A md_done arriving in the MD_START cycle is ignored.
- MD_WB: resultSrc 11, regWrite. Then FETCH.
- TRAP: illegal=1, all strobes 0. Stays in TRAP until reset.

## Timing
- Reset: state=FETCH asynchronously. While rst=0, PCWrite, IRWrite, regWrite, memWrite, md_start and illegal are all 0, and selects take their FETCH values.
- First fetch occurs on the first rising edge after rst releases.
- Cycles per instruction with mem_ready tied high:
  - R, I, jal, lui: 4
  - jalr: 4
  - lw: 5
  - sw: 4
  - branch: 3
  - mul/div: 5 + (cycles until md_done)
- Each mem_ready wait cycle adds one cycle in FETCH, MEMREAD or MEMWRITE.
- A reset asserted mid-instruction aborts it with no further writes. A pending mul/div result is discarded.

## Test plan
- add x3,x1,x2 (0x002081B3), mem_ready=1 → states FETCH, DECODE, EXECR, ALUWB; regWrite=1 only in cycle 4 with resultSrc=00 and ALUControl=0.
- lw with MEM_HANDSHAKE=1, mem_ready low for 2 cycles in FETCH and 3 in MEMREAD → IRWrite and PCWrite single-cycle at the ready edge; total 10 cycles; regWrite with resultSrc=01.
- bltu with ltu=1, then ltu=0 → PCWrite=1, then PCWrite=0 in the BRANCH cycle; func3=010 → illegal=1 persists until reset.
- jalr → JALR cycle has PCWrite=1 and resultSrc=10; LINK cycle has regWrite=1 with ALUSrcA=01 and ALUSrcB=10.
- MEXT=1 mul (func7=0000001), md_done after 6 cycles → md_start high exactly 1 cycle, regWrite with resultSrc=11 one cycle after md_done. With MEXT=0 → TRAP.
- rst pulsed low during MEMWRITE with mem_ready=0 → memWrite drops to 0 immediately; after release, FETCH with IRWrite=1.

Source files
------------

// File: rtl/riscv_mc_controller_if.sv
// Control bundle between the multi-cycle controller and the RV32I datapath.
// master: controller side (reads IR fields/flags, drives selects/strobes).
// slave : datapath side (drives IR fields/flags, reads selects/strobes).
interface riscv_mc_controller_if;
   logic [6:0] op;
   logic [2:0] func3;
   logic [6:0] func7;
   logic       zero;
   logic       neg;
   logic       ltu;
   logic       mem_ready;
   logic       md_done;
   logic       PCWrite;
   logic       adrSrc;
   logic       memWrite;
   logic       IRWrite;
   logic       regWrite;
   logic [1:0] resultSrc;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [3:0] ALUControl;
   logic [2:0] immSrc;
   logic       md_start;
   logic       illegal;

   modport master (
      input  op, func3, func7, zero, neg, ltu, mem_ready, md_done,
      output PCWrite, adrSrc, memWrite, IRWrite, regWrite,
      output resultSrc, ALUSrcA, ALUSrcB, ALUControl, immSrc,
      output md_start, illegal
   );

   modport slave (
      output op, func3, func7, zero, neg, ltu, mem_ready, md_done,
      input  PCWrite, adrSrc, memWrite, IRWrite, regWrite,
      input  resultSrc, ALUSrcA, ALUSrcB, ALUControl, immSrc,
      input  md_start, illegal
   );
endinterface

// File: rtl/riscv_mc_controller.sv
// Multi-cycle RV32I(+M) control FSM: clk, rst (async active-low) and the
// controller_if master port carrying IR fields/flags in, selects/strobes out.
module riscv_mc_controller #(
   parameter bit MEM_HANDSHAKE = 1'b1,
   parameter bit MEXT          = 1'b1
) (
   input logic                   clk,
   input logic                   rst,
   riscv_mc_controller_if.master bus
);

   typedef enum logic [4:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
      S_MEMWRITE, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH,
      S_JAL, S_JALR, S_LINK, S_LUI, S_MD_START,
      S_MD_WAIT, S_MD_WB, S_TRAP
   } state_t;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;

   localparam logic [3:0] A_ADD  = 4'd0;
   localparam logic [3:0] A_SUB  = 4'd1;
   localparam logic [3:0] A_AND  = 4'd2;
   localparam logic [3:0] A_OR   = 4'd3;
   localparam logic [3:0] A_XOR  = 4'd4;
   localparam logic [3:0] A_SLT  = 4'd5;
   localparam logic [3:0] A_SLTU = 4'd6;
   localparam logic [3:0] A_SLL  = 4'd7;
   localparam logic [3:0] A_SRL  = 4'd8;
   localparam logic [3:0] A_SRA  = 4'd9;

   state_t state, nxt;

   logic       rdy;
   logic       taken, br_ok;
   logic       is_r, f7z, f7s;
   logic [3:0] alu_op;
   logic       alu_ok;
   logic       md_op;
   logic       pcupd, branch;
   logic       irw;

   assign rdy   = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;
   assign is_r  = (state == S_EXECR);
   assign f7z   = (bus.func7 == 7'b0000000);
   assign f7s   = (bus.func7 == 7'b0100000);
   assign md_op = MEXT && (bus.func7 == 7'b0000001);

   always_comb begin
      taken = 1'b0;
      br_ok = 1'b1;
      case (bus.func3)
         3'b000:  taken = bus.zero;
         3'b001:  taken = !bus.zero;
         3'b100:  taken = bus.neg;
         3'b101:  taken = !bus.neg;
         3'b110:  taken = bus.ltu;
         3'b111:  taken = !bus.ltu;
         default: br_ok = 1'b0;
      endcase
   end

   // I-type only constrains func7 on shifts; sub exists only for R-type.
   always_comb begin
      alu_op = A_ADD;
      alu_ok = 1'b1;
      case (bus.func3)
         3'b000: begin
            alu_op = (is_r && f7s) ? A_SUB : A_ADD;
            alu_ok = !is_r || f7z || f7s;
         end
         3'b001: begin
            alu_op = A_SLL;
            alu_ok = f7z;
         end
         3'b010: begin
            alu_op = A_SLT;
            alu_ok = !is_r || f7z;
         end
         3'b011: begin
            alu_op = A_SLTU;
            alu_ok = !is_r || f7z;
         end
         3'b100: begin
            alu_op = A_XOR;
            alu_ok = !is_r || f7z;
         end
         3'b101: begin
            alu_op = bus.func7[5] ? A_SRA : A_SRL;
            alu_ok = f7z || f7s;
         end
         3'b110: begin
            alu_op = A_OR;
            alu_ok = !is_r || f7z;
         end
         default: begin
            alu_op = A_AND;
            alu_ok = !is_r || f7z;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_FETCH;
      else      state <= nxt;
   end

   always_comb begin
      nxt            = state;
      pcupd          = 1'b0;
      branch         = 1'b0;
      irw            = 1'b0;
      bus.adrSrc     = 1'b0;
      bus.memWrite   = 1'b0;
      bus.regWrite   = 1'b0;
      bus.resultSrc  = 2'b00;
      bus.ALUSrcA    = 2'b00;
      bus.ALUSrcB    = 2'b00;
      bus.ALUControl = A_ADD;
      bus.immSrc     = 3'd0;
      bus.md_start   = 1'b0;
      bus.illegal    = 1'b0;
      unique case (state)
         S_FETCH: begin
            bus.ALUSrcB   = 2'b10;
            bus.resultSrc = 2'b10;
            irw           = rdy;
            pcupd         = rdy;
            if (rdy) nxt = S_DECODE;
         end
         S_DECODE: begin
            bus.ALUSrcA = 2'b01;
            bus.ALUSrcB = 2'b01;
            if (bus.op == OP_BR)  bus.immSrc = 3'd2;
            if (bus.op == OP_JAL) bus.immSrc = 3'd3;
            unique case (1'b1)
               (bus.op == OP_LOAD),
               (bus.op == OP_STORE): nxt = S_MEMADR;
               (bus.op == OP_R):     nxt = md_op ? S_MD_START : S_EXECR;
               (bus.op == OP_I):     nxt = S_EXECI;
               (bus.op == OP_BR):    nxt = br_ok ? S_BRANCH : S_TRAP;
               (bus.op == OP_JAL):   nxt = S_JAL;
               (bus.op == OP_JALR):  nxt = S_JALR;
               (bus.op == OP_LUI):   nxt = S_LUI;
               default:              nxt = S_TRAP;
            endcase
         end
         S_MEMADR: begin
            bus.ALUSrcA = 2'b10;
            bus.ALUSrcB = 2'b01;
            bus.immSrc  = (bus.op == OP_STORE) ? 3'd1 : 3'd0;
            nxt = (bus.op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            bus.adrSrc = 1'b1;
            if (rdy) nxt = S_MEMWB;
         end
         S_MEMWB: begin
            bus.resultSrc = 2'b01;
            bus.regWrite  = 1'b1;
            nxt = S_FETCH;
         end
         S_MEMWRITE: begin
            bus.adrSrc   = 1'b1;
            bus.memWrite = 1'b1;
            if (rdy) nxt = S_FETCH;
         end
         S_EXECR, S_EXECI: begin
            bus.ALUSrcA    = 2'b10;
            bus.ALUSrcB    = is_r ? 2'b00 : 2'b01;
            bus.ALUControl = alu_op;
            nxt = alu_ok ? S_ALUWB : S_TRAP;
         end
         S_ALUWB: begin
            bus.regWrite = 1'b1;
            nxt = S_FETCH;
         end
         S_BRANCH: begin
            bus.ALUSrcA    = 2'b10;
            bus.ALUControl = A_SUB;
            branch         = 1'b1;
            nxt = S_FETCH;
         end
         S_JAL: begin
            bus.ALUSrcA = 2'b01;
            bus.ALUSrcB = 2'b10;
            pcupd       = 1'b1;
            nxt = S_ALUWB;
         end
         S_JALR: begin
            bus.ALUSrcA   = 2'b10;
            bus.ALUSrcB   = 2'b01;
            bus.resultSrc = 2'b10;
            pcupd         = 1'b1;
            nxt = S_LINK;
         end
         S_LINK: begin
            bus.ALUSrcA   = 2'b01;
            bus.ALUSrcB   = 2'b10;
            bus.resultSrc = 2'b10;
            bus.regWrite  = 1'b1;
            nxt = S_FETCH;
         end
         S_LUI: begin
            bus.ALUSrcA = 2'b11;
            bus.ALUSrcB = 2'b01;
            bus.immSrc  = 3'd4;
            nxt = S_ALUWB;
         end
         S_MD_START: begin
            bus.md_start = 1'b1;
            nxt = S_MD_WAIT;
         end
         S_MD_WAIT: begin
            if (bus.md_done) nxt = S_MD_WB;
         end
         S_MD_WB: begin
            bus.resultSrc = 2'b11;
            bus.regWrite  = 1'b1;
            nxt = S_FETCH;
         end
         S_TRAP: begin
            bus.illegal = 1'b1;
         end
         default: nxt = S_TRAP;
      endcase
   end

   // state sits in FETCH during reset; keep its ready-driven strobes quiet
   assign bus.IRWrite = rst && irw;
   assign bus.PCWrite = rst && (pcupd || (branch && taken));

endmodule
